// File: rtl/ps2_line_conditioner.sv
// ----------------------------------------------------------------------------
// ps2_line_conditioner
//
// Front end for the PS/2 keyboard receiver. The raw pad lines are brought
// into the clk domain through a plain flop chain and then de-glitched. The
// filtered clock is watched for falling edges. Each falling edge gives a
// one-cycle strobe together with the data level seen at that edge.
//
// A small two-state tracker counts the edges of an 11-bit frame. A watchdog
// discards a frame that stops partway, so the receiver never waits forever
// on a half-received frame.
//
// Parameters:
//   SYNC_STAGES    synchronizer flops per line (2 or more)
//   FILTER_LEN     consecutive differing samples needed to move a filtered
//                  line (1 or more)
//   TIMEOUT_CYCLES clk cycles without a falling edge before an open frame is
//                  aborted
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ps2_clk_raw  raw PS/2 clock from the pad
//   ps2_dat_raw  raw PS/2 data from the pad
//   kbclk        filtered PS/2 clock level
//   kbdat        filtered PS/2 data level
//   fall_stb     one-cycle pulse on each filtered kbclk falling edge
//   data_bit     kbdat level captured with the most recent fall_stb
//   bit_idx      falling edges seen in the current frame (0..10)
//   frame_done   one-cycle pulse on the 11th falling edge of a frame
//   stop_ok      stop bit of the last completed frame was 1 (held)
//   frame_abort  one-cycle pulse when the watchdog drops an open frame
//   line_idle    tracker idle and filtered clock high
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// ps2_line_conditioner_chk
//
// Invariant monitor for the conditioner outputs. It is instantiated inside
// the top level. It adds no logic to the datapath.
// Ports: the clock, the reset and the conditioner output pulses it observes.
// ----------------------------------------------------------------------------
module ps2_line_conditioner_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       fall_stb,
  input logic       frame_done,
  input logic       frame_abort,
  input logic [3:0] bit_idx
);

  // A frame can end in only one way in a given cycle.
  a_done_abort_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(frame_done && frame_abort));

  // A frame completes only on a falling edge.
  a_done_on_edge : assert property (@(posedge clk) disable iff (!rst_n)
    frame_done |-> fall_stb);

  // A falling edge always beats a watchdog expiry in the same cycle.
  a_abort_no_edge : assert property (@(posedge clk) disable iff (!rst_n)
    frame_abort |-> !fall_stb);

  // The frame position never runs past the stop bit.
  a_idx_range : assert property (@(posedge clk) disable iff (!rst_n)
    bit_idx <= 4'd10);

endmodule

module ps2_line_conditioner #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_raw,
  input  logic       ps2_dat_raw,
  output logic       kbclk,
  output logic       kbdat,
  output logic       fall_stb,
  output logic       data_bit,
  output logic [3:0] bit_idx,
  output logic       frame_done,
  output logic       stop_ok,
  output logic       frame_abort,
  output logic       line_idle
);

  // The filter counter only needs to reach FILTER_LEN-1. The count that
  // would reach FILTER_LEN is the one that flips the line.
  localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;

  localparam logic [3:0] IDX_STOP = 4'd10;

  // Synchronizer chains
  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] dat_sync_r;
  logic                   clk_sync_s;
  logic                   dat_sync_s;

  // Filters
  logic [FCNT_W-1:0] clk_cnt_r;
  logic [FCNT_W-1:0] dat_cnt_r;
  logic [FCNT_W-1:0] clk_cnt_nxt_s;
  logic [FCNT_W-1:0] dat_cnt_nxt_s;
  logic              kbclk_r;
  logic              kbdat_r;
  logic              clk_flip_s;
  logic              dat_flip_s;
  logic              kbclk_nxt_s;
  logic              kbdat_nxt_s;

  // Edge detect and frame tracking
  logic              fall_s;
  logic              fall_stb_r;
  logic              data_bit_r;
  logic              data_bit_nxt_s;
  logic [0:0]        state_r;
  logic [0:0]        state_nxt_s;
  logic [3:0]        bit_idx_r;
  logic [3:0]        bit_idx_nxt_s;
  logic [WD_W-1:0]   wd_r;
  logic [WD_W-1:0]   wd_nxt_s;
  logic              frame_done_r;
  logic              frame_done_nxt_s;
  logic              stop_ok_r;
  logic              stop_ok_nxt_s;
  logic              frame_abort_r;
  logic              frame_abort_nxt_s;
  logic              line_idle_r;
  logic              line_idle_nxt_s;

  // Pad-to-clk synchronizer chains, plain flop-to-flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_r <= {SYNC_STAGES{1'b1}};
      dat_sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk_raw};
      dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], ps2_dat_raw};
    end
  end

  assign clk_sync_s = clk_sync_r[SYNC_STAGES-1];
  assign dat_sync_s = dat_sync_r[SYNC_STAGES-1];

  // Filter next state. A line flips only on the last sample of an unbroken
  // run of differing samples. Any agreeing sample restarts the run.
  always_comb begin
    clk_flip_s = (clk_sync_s != kbclk_r) && (clk_cnt_r == FCNT_LAST);
    dat_flip_s = (dat_sync_s != kbdat_r) && (dat_cnt_r == FCNT_LAST);

    if ((clk_sync_s == kbclk_r) || clk_flip_s) begin
      clk_cnt_nxt_s = {FCNT_W{1'b0}};
    end else begin
      clk_cnt_nxt_s = clk_cnt_r + FCNT_W'(1);
    end

    if ((dat_sync_s == kbdat_r) || dat_flip_s) begin
      dat_cnt_nxt_s = {FCNT_W{1'b0}};
    end else begin
      dat_cnt_nxt_s = dat_cnt_r + FCNT_W'(1);
    end

    if (clk_flip_s) begin
      kbclk_nxt_s = ~kbclk_r;
    end else begin
      kbclk_nxt_s = kbclk_r;
    end

    if (dat_flip_s) begin
      kbdat_nxt_s = ~kbdat_r;
    end else begin
      kbdat_nxt_s = kbdat_r;
    end
  end

  // Filter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt_r <= {FCNT_W{1'b0}};
      dat_cnt_r <= {FCNT_W{1'b0}};
      kbclk_r   <= 1'b1;
      kbdat_r   <= 1'b1;
    end else begin
      clk_cnt_r <= clk_cnt_nxt_s;
      dat_cnt_r <= dat_cnt_nxt_s;
      kbclk_r   <= kbclk_nxt_s;
      kbdat_r   <= kbdat_nxt_s;
    end
  end

  // The strobe is taken from the filter's next value. This makes the
  // registered fall_stb line up with the first cycle in which kbclk reads 0.
  assign fall_s = kbclk_r & ~kbclk_nxt_s;

  // Frame tracker and watchdog. The data bit used for a decision is the
  // kbdat level at the edge. That is the value data_bit takes in the same
  // cycle.
  always_comb begin
    state_nxt_s       = state_r;
    bit_idx_nxt_s     = bit_idx_r;
    wd_nxt_s          = wd_r;
    frame_done_nxt_s  = 1'b0;
    frame_abort_nxt_s = 1'b0;
    stop_ok_nxt_s     = stop_ok_r;

    if (fall_s) begin
      data_bit_nxt_s = kbdat_r;
    end else begin
      data_bit_nxt_s = data_bit_r;
    end

    case (state_r)
      ST_IDLE: begin
        wd_nxt_s = {WD_W{1'b0}};
        if (fall_s && !kbdat_r) begin
          state_nxt_s   = ST_FRAME;
          bit_idx_nxt_s = 4'd1;
        end else begin
          bit_idx_nxt_s = 4'd0;
        end
      end
      ST_FRAME: begin
        if (fall_s) begin
          wd_nxt_s = {WD_W{1'b0}};
          if (bit_idx_r >= IDX_STOP) begin
            frame_done_nxt_s = 1'b1;
            stop_ok_nxt_s    = kbdat_r;
            state_nxt_s      = ST_IDLE;
            bit_idx_nxt_s    = 4'd0;
          end else begin
            bit_idx_nxt_s = bit_idx_r + 4'd1;
          end
        end else if (wd_r == WD_LAST) begin
          frame_abort_nxt_s = 1'b1;
          state_nxt_s       = ST_IDLE;
          bit_idx_nxt_s     = 4'd0;
          wd_nxt_s          = {WD_W{1'b0}};
        end else begin
          wd_nxt_s = wd_r + WD_W'(1);
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        bit_idx_nxt_s = 4'd0;
        wd_nxt_s      = {WD_W{1'b0}};
      end
    endcase

    line_idle_nxt_s = (state_nxt_s == ST_IDLE) && kbclk_nxt_s;
  end

  // Edge, tracker and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fall_stb_r    <= 1'b0;
      data_bit_r    <= 1'b1;
      state_r       <= ST_IDLE;
      bit_idx_r     <= 4'd0;
      wd_r          <= {WD_W{1'b0}};
      frame_done_r  <= 1'b0;
      stop_ok_r     <= 1'b0;
      frame_abort_r <= 1'b0;
      line_idle_r   <= 1'b1;
    end else begin
      fall_stb_r    <= fall_s;
      data_bit_r    <= data_bit_nxt_s;
      state_r       <= state_nxt_s;
      bit_idx_r     <= bit_idx_nxt_s;
      wd_r          <= wd_nxt_s;
      frame_done_r  <= frame_done_nxt_s;
      stop_ok_r     <= stop_ok_nxt_s;
      frame_abort_r <= frame_abort_nxt_s;
      line_idle_r   <= line_idle_nxt_s;
    end
  end

  assign kbclk       = kbclk_r;
  assign kbdat       = kbdat_r;
  assign fall_stb    = fall_stb_r;
  assign data_bit    = data_bit_r;
  assign bit_idx     = bit_idx_r;
  assign frame_done  = frame_done_r;
  assign stop_ok     = stop_ok_r;
  assign frame_abort = frame_abort_r;
  assign line_idle   = line_idle_r;

  ps2_line_conditioner_chk u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .fall_stb    (fall_stb_r),
    .frame_done  (frame_done_r),
    .frame_abort (frame_abort_r),
    .bit_idx     (bit_idx_r)
  );

endmodule

// File: tb/tb_ps2_line_conditioner.sv
// Testbench for ps2_line_conditioner. A cycle-level reference model is
// built from the line and frame rules and compared every cycle. Directed
// checks cover glitch rejection, clean and bad frames, stalled frames,
// spurious edges and reset in mid-frame.
module tb_ps2_line_conditioner;

  localparam int SYNC = 2;
  localparam int FLEN = 4;
  localparam int TMO  = 100;
  localparam int HALF = 20;

  localparam logic [11:0] RESET_VEC = 12'b1101_0000_0001;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk_raw;
  logic       ps2_dat_raw;
  logic       kbclk;
  logic       kbdat;
  logic       fall_stb;
  logic       data_bit;
  logic [3:0] bit_idx;
  logic       frame_done;
  logic       stop_ok;
  logic       frame_abort;
  logic       line_idle;
  logic [11:0] dut_vec;

  ps2_line_conditioner #(
    .SYNC_STAGES    (SYNC),
    .FILTER_LEN     (FLEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk_raw (ps2_clk_raw),
    .ps2_dat_raw (ps2_dat_raw),
    .kbclk       (kbclk),
    .kbdat       (kbdat),
    .fall_stb    (fall_stb),
    .data_bit    (data_bit),
    .bit_idx     (bit_idx),
    .frame_done  (frame_done),
    .stop_ok     (stop_ok),
    .frame_abort (frame_abort),
    .line_idle   (line_idle)
  );

  assign dut_vec = {kbclk, kbdat, fall_stb, data_bit, bit_idx,
                    frame_done, stop_ok, frame_abort, line_idle};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  // Reference model state
  logic m_cq[$];
  logic m_dq[$];
  logic m_cw[$];
  logic m_dw[$];
  logic m_bits[$];
  logic m_kbclk, m_kbdat, m_fall, m_data_bit, m_done, m_stop, m_abort, m_in_frame;
  int   m_cyc;
  int   m_last_fall;

  // Observations taken from the DUT
  logic       obs_bits[$];
  logic [3:0] obs_idx[$];
  int         obs_fall_cyc[$];
  int         n_done;
  int         n_abort;
  int         obs_abort_cyc;
  logic       obs_stop;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic all_differ(input logic w[$], input logic cur);
    logic r;
    r = (w.size() == FLEN);
    foreach (w[i]) begin
      if (w[i] == cur) r = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [11:0] exp_vec();
    logic [3:0] idx;
    idx = m_in_frame ? 4'(m_bits.size()) : 4'd0;
    return {m_kbclk, m_kbdat, m_fall, m_data_bit, idx,
            m_done, m_stop, m_abort, (!m_in_frame && m_kbclk)};
  endfunction

  task automatic model_reset();
    m_cq.delete(); m_dq.delete(); m_cw.delete(); m_dw.delete(); m_bits.delete();
    for (int i = 0; i < SYNC; i++) begin
      m_cq.push_back(1'b1);
      m_dq.push_back(1'b1);
    end
    m_kbclk = 1'b1; m_kbdat = 1'b1; m_fall = 1'b0; m_data_bit = 1'b1;
    m_done = 1'b0; m_stop = 1'b0; m_abort = 1'b0; m_in_frame = 1'b0;
    m_last_fall = m_cyc;
  endtask

  // One rising edge of the model with raw levels c/d sampled.
  task automatic model_edge(input logic c, input logic d);
    logic cs, ds, nclk, ndat, fall, bitv;
    m_cyc++;
    cs = m_cq.pop_front(); m_cq.push_back(c);
    ds = m_dq.pop_front(); m_dq.push_back(d);
    m_cw.push_back(cs); if (m_cw.size() > FLEN) void'(m_cw.pop_front());
    m_dw.push_back(ds); if (m_dw.size() > FLEN) void'(m_dw.pop_front());
    nclk = all_differ(m_cw, m_kbclk) ? ~m_kbclk : m_kbclk;
    ndat = all_differ(m_dw, m_kbdat) ? ~m_kbdat : m_kbdat;
    fall = m_kbclk & ~nclk;
    bitv = m_kbdat;
    m_kbclk = nclk;
    m_kbdat = ndat;
    m_fall = fall; m_done = 1'b0; m_abort = 1'b0;
    if (fall) begin
      m_data_bit = bitv;
      m_last_fall = m_cyc;
      if (!m_in_frame) begin
        if (bitv == 1'b0) begin
          m_in_frame = 1'b1;
          m_bits.delete();
          m_bits.push_back(bitv);
        end
      end else begin
        m_bits.push_back(bitv);
        if (m_bits.size() == 11) begin
          m_done = 1'b1;
          m_stop = bitv;
          m_in_frame = 1'b0;
        end
      end
    end else if (m_in_frame && (m_cyc - m_last_fall) == TMO) begin
      m_abort = 1'b1;
      m_in_frame = 1'b0;
    end
  endtask

  task automatic clear_obs();
    obs_bits.delete(); obs_idx.delete(); obs_fall_cyc.delete();
    n_done = 0; n_abort = 0; obs_abort_cyc = 0; obs_stop = 1'b0;
  endtask

  // Drive one cycle of raw levels, then compare the DUT against the model.
  task automatic step(input logic c, input logic d);
    ps2_clk_raw = c;
    ps2_dat_raw = d;
    @(posedge clk);
    model_edge(c, d);
    #1;
    check("cycle", int'(dut_vec), int'(exp_vec()));
    if (fall_stb) begin
      obs_bits.push_back(data_bit);
      obs_idx.push_back(bit_idx);
      obs_fall_cyc.push_back(m_cyc);
    end
    if (frame_done) begin
      n_done++;
      obs_stop = stop_ok;
    end
    if (frame_abort) begin
      n_abort++;
      obs_abort_cyc = m_cyc;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic stop);
    return {stop, ~^b, b, 1'b0};
  endfunction

  // 40-cycle bit cells: clock high 20, low 20, data set at cell start.
  task automatic send_bits(input logic [10:0] f, input int n, input bit glitch);
    int g, gs;
    logic cv;
    for (int i = 0; i < n; i++) begin
      g  = glitch ? int'($urandom_range(1, 3)) : 0;
      gs = int'($urandom_range(4, 10));
      for (int c = 0; c < 2 * HALF; c++) begin
        cv = (c < HALF) && !(c >= gs && c < gs + g);
        step(cv, f[i]);
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [10:0] f, input logic exp_stop);
    check({tag, "_nfall"}, obs_bits.size(), 11);
    for (int i = 0; i < obs_bits.size() && i < 11; i++) begin
      check({tag, "_bit"}, int'(obs_bits[i]), int'(f[i]));
      check({tag, "_idx"}, int'(obs_idx[i]), (i == 10) ? 0 : i + 1);
    end
    check({tag, "_done"}, n_done, 1);
    check({tag, "_abort"}, n_abort, 0);
    check({tag, "_stop"}, int'(obs_stop), int'(exp_stop));
    check({tag, "_idle"}, int'(line_idle), 1);
    check({tag, "_idx0"}, int'(bit_idx), 0);
  endtask

  initial begin
    logic [10:0] f;
    logic [7:0]  b;
    logic [7:0]  rb;
    int          start;
    n_chk = 0;
    n_pass = 0;
    m_cyc = 0;
    rst_n = 1'b0;
    ps2_clk_raw = 1'b1;
    ps2_dat_raw = 1'b1;
    model_reset();
    clear_obs();
    repeat (3) @(negedge clk);
    check("reset", int'(dut_vec), int'(RESET_VEC));
    rst_n = 1'b1;
    idle(10);

    // 1. Glitch rejection: 3-cycle low pulse ignored, 4-cycle pulse accepted.
    clear_obs();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1);
      check("glitch_kbclk", int'(kbclk), 1);
    end
    check("glitch_nofall", obs_bits.size(), 0);
    clear_obs();
    start = m_cyc;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    idle(12);
    check("pulse4_nfall", obs_fall_cyc.size(), 1);
    if (obs_fall_cyc.size() > 0) check("pulse4_edge", obs_fall_cyc[0] - start, 6);
    check("pulse4_idx", int'(bit_idx), 0);
    idle(10);

    // 2. Clean 0x1C frame.
    clear_obs();
    f = make_frame(8'h1C, 1'b1);
    send_bits(f, 11, 1'b0);
    idle(20);
    check_frame("frame1c", f, 1'b1);

    // 3. Same frame with a bad stop bit.
    clear_obs();
    f = make_frame(8'h1C, 1'b0);
    send_bits(f, 11, 1'b0);
    idle(20);
    check_frame("badstop", f, 1'b0);

    // 4. Stalled frame, then a full 0xF0 frame.
    clear_obs();
    f = make_frame(8'hA5, 1'b1);
    send_bits(f, 5, 1'b0);
    for (int k = 0; k < 150 && n_abort == 0; k++) step(1'b1, 1'b1);
    check("stall_abort", n_abort, 1);
    if (obs_fall_cyc.size() > 0)
      check("stall_delay", obs_abort_cyc - obs_fall_cyc[obs_fall_cyc.size() - 1], TMO);
    check("stall_idx", int'(bit_idx), 0);
    check("stall_nodone", n_done, 0);
    idle(10);
    clear_obs();
    f = make_frame(8'hF0, 1'b1);
    send_bits(f, 11, 1'b0);
    idle(20);
    check_frame("frame_f0", f, 1'b1);

    // 5. Spurious falling edge in idle with data high.
    clear_obs();
    send_bits(11'h7FF, 1, 1'b0);
    idle(10);
    check("spur_nfall", obs_bits.size(), 1);
    check("spur_idx", int'(bit_idx), 0);
    check("spur_done", n_done, 0);
    check("spur_abort", n_abort, 0);

    // Randomized frames with short clock glitches inside the high phase.
    for (int r = 0; r < 4; r++) begin
      clear_obs();
      b = 8'($urandom);
      f = make_frame(b, 1'b1);
      send_bits(f, 11, 1'b1);
      idle(20);
      check_frame("rand", f, 1'b1);
      rb = 8'd0;
      for (int i = 1; i <= 8 && i < obs_bits.size(); i++) rb[i-1] = obs_bits[i];
      check("rand_byte", int'(rb), int'(b));
    end

    // 6. Asynchronous reset at bit_idx 5, then a normal frame.
    clear_obs();
    f = make_frame(8'h1C, 1'b1);
    send_bits(f, 5, 1'b0);
    check("midrst_idx5", int'(bit_idx), 5);
    ps2_clk_raw = 1'b1;
    ps2_dat_raw = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_async", int'(dut_vec), int'(RESET_VEC));
    repeat (3) @(negedge clk);
    check("midrst_hold", int'(dut_vec), int'(RESET_VEC));
    rst_n = 1'b1;
    model_reset();
    idle(10);
    clear_obs();
    send_bits(f, 11, 1'b0);
    idle(20);
    check_frame("postrst", f, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
